// File: rtl/uart_rx_pkt_ctrl_if.sv
// Byte-level bus between the UART receiver, the packet controller and downstream.
// master = receiver/downstream side, slave = packet controller.
interface uart_rx_pkt_ctrl_if #(
    parameter int BYTE = 8
);
    logic            rx_valid;
    logic [BYTE-1:0] rx_byte;
    logic [BYTE-1:0] pkt_data;
    logic            pkt_valid;
    logic            pkt_ready;
    logic            pkt_last;
    logic [7:0]      pkt_len;
    logic            busy;
    logic            err_len;
    logic            err_chk;
    logic            err_timeout;
    logic            err_overflow;

    modport master (
        output rx_valid, rx_byte, pkt_ready,
        input  pkt_data, pkt_valid, pkt_last, pkt_len, busy,
               err_len, err_chk, err_timeout, err_overflow
    );

    modport slave (
        input  rx_valid, rx_byte, pkt_ready,
        output pkt_data, pkt_valid, pkt_last, pkt_len, busy,
               err_len, err_chk, err_timeout, err_overflow
    );
endinterface

// File: rtl/uart_rx_pkt_ctrl.sv
// Packet framer behind the UART receiver: SYNC, LEN, payload, XOR checksum.
// Verified payloads are buffered and drained on a valid/ready byte stream.
module uart_rx_pkt_ctrl #(
    parameter int              CLK_FRQ      = 250000000,
    parameter int              BAUD_RATE    = 115200,
    parameter int              BYTE         = 8,
    parameter int              MAX_LEN      = 16,
    parameter logic [BYTE-1:0] SYNC         = 8'hA5,
    parameter int              TIMEOUT_BITS = 20
) (
    input logic               clk,
    input logic               areset,
    uart_rx_pkt_ctrl_if.slave bus
);
    localparam int BAUD_DIV = CLK_FRQ / BAUD_RATE;
    localparam int LIMIT    = TIMEOUT_BITS * BAUD_DIV;
    localparam int CNT_W    = $clog2(LIMIT + 1);
    localparam int AW       = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;

    typedef enum logic [2:0] {HUNT, LEN, PAYLOAD, CHECK, DRAIN} state_t;

    state_t          state_q, state_d;
    logic [7:0]      idx_q, idx_d, len_q, len_d, pkt_len_q, pkt_len_d;
    logic [BYTE-1:0] acc_q, acc_d, pkt_data_q, pkt_data_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic            pkt_valid_q, pkt_valid_d, pkt_last_q, pkt_last_d;
    logic            err_len_q, err_len_d, err_chk_q, err_chk_d;
    logic            err_to_q, err_to_d, err_ov_q, err_ov_d;
    logic            buf_we;
    logic [7:0]      nxt;
    logic [BYTE-1:0] buf_q [0:(1<<AW)-1];

    assign nxt = idx_q + 8'd1;

    always_comb begin
        state_d     = state_q;
        idx_d       = idx_q;
        len_d       = len_q;
        acc_d       = acc_q;
        cnt_d       = '0;
        pkt_data_d  = pkt_data_q;
        pkt_valid_d = pkt_valid_q;
        pkt_last_d  = pkt_last_q;
        pkt_len_d   = pkt_len_q;
        err_len_d   = 1'b0;
        err_chk_d   = 1'b0;
        err_to_d    = 1'b0;
        err_ov_d    = 1'b0;
        buf_we      = 1'b0;
        case (state_q)
            HUNT: if (bus.rx_valid && bus.rx_byte == SYNC) state_d = LEN;
            LEN, PAYLOAD, CHECK: begin
                if (!bus.rx_valid) begin
                    // A byte landing on the expiry cycle takes the other branch and wins.
                    if (cnt_q == CNT_W'(LIMIT - 1)) begin
                        err_to_d = 1'b1;
                        state_d  = HUNT;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end else if (state_q == LEN) begin
                    if (bus.rx_byte != '0 && int'(bus.rx_byte) <= MAX_LEN) begin
                        len_d   = 8'(bus.rx_byte);
                        acc_d   = bus.rx_byte;
                        idx_d   = 8'd0;
                        state_d = PAYLOAD;
                    end else begin
                        err_len_d = 1'b1;
                        state_d   = HUNT;
                    end
                end else if (state_q == PAYLOAD) begin
                    buf_we = 1'b1;
                    acc_d  = acc_q ^ bus.rx_byte;
                    idx_d  = nxt;
                    if (idx_q == len_q - 8'd1) state_d = CHECK;
                end else begin
                    if (bus.rx_byte == acc_q) begin
                        idx_d       = 8'd0;
                        pkt_len_d   = len_q;
                        pkt_valid_d = 1'b1;
                        pkt_data_d  = buf_q[0];
                        pkt_last_d  = (len_q == 8'd1);
                        state_d     = DRAIN;
                    end else begin
                        err_chk_d = 1'b1;
                        state_d   = HUNT;
                    end
                end
            end
            DRAIN: begin
                err_ov_d = bus.rx_valid;
                if (pkt_valid_q && bus.pkt_ready) begin
                    if (pkt_last_q) begin
                        pkt_valid_d = 1'b0;
                        pkt_last_d  = 1'b0;
                        state_d     = HUNT;
                    end else begin
                        idx_d      = nxt;
                        pkt_data_d = buf_q[nxt[AW-1:0]];
                        pkt_last_d = (nxt == pkt_len_q - 8'd1);
                    end
                end
            end
            default: state_d = HUNT;
        endcase
    end

    always_ff @(posedge clk or posedge areset) begin
        if (areset) begin
            state_q     <= HUNT;
            idx_q       <= '0;
            len_q       <= '0;
            acc_q       <= '0;
            cnt_q       <= '0;
            pkt_data_q  <= '0;
            pkt_valid_q <= 1'b0;
            pkt_last_q  <= 1'b0;
            pkt_len_q   <= '0;
            err_len_q   <= 1'b0;
            err_chk_q   <= 1'b0;
            err_to_q    <= 1'b0;
            err_ov_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            len_q       <= len_d;
            acc_q       <= acc_d;
            cnt_q       <= cnt_d;
            pkt_data_q  <= pkt_data_d;
            pkt_valid_q <= pkt_valid_d;
            pkt_last_q  <= pkt_last_d;
            pkt_len_q   <= pkt_len_d;
            err_len_q   <= err_len_d;
            err_chk_q   <= err_chk_d;
            err_to_q    <= err_to_d;
            err_ov_q    <= err_ov_d;
        end
    end

    always_ff @(posedge clk) begin
        if (buf_we) buf_q[idx_q[AW-1:0]] <= bus.rx_byte;
    end

    assign bus.pkt_data     = pkt_data_q;
    assign bus.pkt_valid    = pkt_valid_q;
    assign bus.pkt_last     = pkt_last_q;
    assign bus.pkt_len      = pkt_len_q;
    assign bus.busy         = (state_q != HUNT);
    assign bus.err_len      = err_len_q;
    assign bus.err_chk      = err_chk_q;
    assign bus.err_timeout  = err_to_q;
    assign bus.err_overflow = err_ov_q;
endmodule

// File: tb/tb_uart_rx_pkt_ctrl.sv
// Directed bench for uart_rx_pkt_ctrl: good frames, bad checksum/length,
// timeout boundary, overflow under back-pressure and async reset.
module tb_uart_rx_pkt_ctrl;
    localparam int CLK_FRQ      = 1000000;
    localparam int BAUD_RATE    = 100000;
    localparam int TIMEOUT_BITS = 20;
    localparam int MAX_LEN      = 16;
    localparam int LIMIT        = TIMEOUT_BITS * (CLK_FRQ / BAUD_RATE);

    logic clk = 1'b0;
    logic areset;
    always #5 clk = ~clk;

    uart_rx_pkt_ctrl_if #(.BYTE(8)) u_if();

    uart_rx_pkt_ctrl #(
        .CLK_FRQ(CLK_FRQ), .BAUD_RATE(BAUD_RATE), .BYTE(8),
        .MAX_LEN(MAX_LEN), .SYNC(8'hA5), .TIMEOUT_BITS(TIMEOUT_BITS)
    ) dut (
        .clk(clk), .areset(areset), .bus(u_if)
    );

    int total = 0;
    int bad   = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", tag, obs, exp);
        end
    endtask

    int n_len = 0, n_chk = 0, n_to = 0, n_ov = 0;
    logic [7:0] got[$];
    bit         gotl[$];

    always @(negedge clk) begin
        if (u_if.err_len)      n_len++;
        if (u_if.err_chk)      n_chk++;
        if (u_if.err_timeout)  n_to++;
        if (u_if.err_overflow) n_ov++;
        if (u_if.pkt_valid && u_if.pkt_ready) begin
            got.push_back(u_if.pkt_data);
            gotl.push_back(u_if.pkt_last);
        end
    end

    task automatic idle(input int n);
        repeat (n) begin @(posedge clk); #1; end
    endtask

    task automatic send_byte(input logic [7:0] b);
        u_if.rx_valid = 1'b1;
        u_if.rx_byte  = b;
        @(posedge clk); #1;
        u_if.rx_valid = 1'b0;
    endtask

    task automatic send_frame(input logic [7:0] f[$]);
        foreach (f[i]) send_byte(f[i]);
    endtask

    task automatic chk_got(input string tag, input int base, input logic [7:0] e[$]);
        chk({tag, ".cnt"}, got.size() - base, e.size());
        foreach (e[i]) begin
            if (base + i < got.size()) begin
                chk({tag, ".data"}, got[base+i], e[i]);
                chk({tag, ".last"}, gotl[base+i], (i == e.size() - 1));
            end
        end
    endtask

    function automatic int errs();
        return n_len + n_chk + n_to + n_ov;
    endfunction

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout want finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic [7:0] f[$];
        logic [7:0] e[$];
        int base, e0, ov0;

        areset = 1'b1;
        u_if.rx_valid = 1'b0; u_if.rx_byte = '0; u_if.pkt_ready = 1'b1;
        idle(2);
        chk("rst.busy", u_if.busy, 0);
        chk("rst.valid", u_if.pkt_valid, 0);
        chk("rst.len", u_if.pkt_len, 0);
        chk("rst.errs", {u_if.err_len, u_if.err_chk, u_if.err_timeout, u_if.err_overflow}, 0);
        areset = 1'b0;
        idle(2);

        // 1: good 3-byte frame, ready tied high
        e0 = errs();
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h74};
        send_frame(f);
        chk("t1.valid0", u_if.pkt_valid, 1);
        chk("t1.data0", u_if.pkt_data, 8'h11);
        chk("t1.last0", u_if.pkt_last, 0);
        chk("t1.len", u_if.pkt_len, 3);
        idle(1);
        chk("t1.data1", u_if.pkt_data, 8'h22);
        idle(1);
        chk("t1.data2", u_if.pkt_data, 8'h44);
        chk("t1.last2", u_if.pkt_last, 1);
        idle(1);
        chk("t1.valid_end", u_if.pkt_valid, 0);
        chk("t1.busy_end", u_if.busy, 0);
        chk("t1.errs", errs() - e0, 0);

        // 2: bad checksum, then a good frame
        base = got.size();
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h75};
        send_frame(f);
        chk("t2.err_chk", u_if.err_chk, 1);
        chk("t2.busy", u_if.busy, 0);
        chk("t2.valid", u_if.pkt_valid, 0);
        idle(1);
        chk("t2.err_chk_w", u_if.err_chk, 0);
        chk("t2.none", got.size() - base, 0);
        f = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h44, 8'h74};
        send_frame(f);
        idle(4);
        e = '{8'h11, 8'h22, 8'h44};
        chk_got("t2.pkt", base, e);

        // 3: junk ignored, zero and oversize lengths rejected
        e0 = errs();
        f = '{8'h00, 8'hFF};
        send_frame(f);
        chk("t3.junk_err", errs() - e0, 0);
        chk("t3.junk_busy", u_if.busy, 0);
        e0 = n_len;
        f = '{8'hA5, 8'h00};
        send_frame(f);
        chk("t3.len0_busy", u_if.busy, 0);
        f = '{8'hA5, 8'h11};
        send_frame(f);
        chk("t3.len17_busy", u_if.busy, 0);
        idle(1);
        chk("t3.n_len", n_len - e0, 2);

        // 4: timeout boundary
        e0 = n_to;
        f = '{8'hA5, 8'h02, 8'h10};
        send_frame(f);
        idle(LIMIT - 1);
        chk("t4.pre_to", u_if.err_timeout, 0);
        chk("t4.pre_busy", u_if.busy, 1);
        idle(1);
        chk("t4.to", u_if.err_timeout, 1);
        chk("t4.to_busy", u_if.busy, 0);
        base = got.size();
        send_frame(f);
        idle(LIMIT - 1);
        send_byte(8'h20);
        chk("t4.edge_busy", u_if.busy, 1);
        send_byte(8'h32);
        idle(3);
        chk("t4.n_to", n_to - e0, 1);
        e = '{8'h10, 8'h20};
        chk_got("t4.pkt", base, e);

        // 5: back-pressure with an overflowing byte
        u_if.pkt_ready = 1'b0;
        ov0 = n_ov;
        base = got.size();
        f = '{8'hA5, 8'h02, 8'hC3, 8'h3C, 8'hFD};
        send_frame(f);
        chk("t5.valid", u_if.pkt_valid, 1);
        idle(10);
        send_byte(8'h5A);
        idle(39);
        chk("t5.n_ov", n_ov - ov0, 1);
        chk("t5.hold_data", u_if.pkt_data, 8'hC3);
        chk("t5.hold_last", u_if.pkt_last, 0);
        chk("t5.hold_valid", u_if.pkt_valid, 1);
        u_if.pkt_ready = 1'b1;
        idle(3);
        e = '{8'hC3, 8'h3C};
        chk_got("t5.pkt", base, e);
        chk("t5.busy_end", u_if.busy, 0);

        // 6: async reset mid-payload and mid-drain
        e0 = errs();
        f = '{8'hA5, 8'h04, 8'h01, 8'h02};
        send_frame(f);
        areset = 1'b1; #1;
        chk("t6a.busy", u_if.busy, 0);
        idle(1);
        areset = 1'b0;
        idle(1);
        u_if.pkt_ready = 1'b0;
        f = '{8'hA5, 8'h01, 8'h55, 8'h54};
        send_frame(f);
        chk("t6b.valid_pre", u_if.pkt_valid, 1);
        areset = 1'b1; #1;
        chk("t6b.out", {u_if.pkt_valid, u_if.pkt_last, u_if.busy, u_if.pkt_len, u_if.pkt_data}, 0);
        idle(1);
        areset = 1'b0;
        u_if.pkt_ready = 1'b1;
        idle(1);
        base = got.size();
        f = '{8'hA5, 8'h01, 8'h7E, 8'h7F};
        send_frame(f);
        chk("t6c.data", u_if.pkt_data, 8'h7E);
        chk("t6c.last", u_if.pkt_last, 1);
        idle(2);
        e = '{8'h7E};
        chk_got("t6c.pkt", base, e);
        chk("t6.errs", errs() - e0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end
endmodule

// File: doc/uart_rx_pkt_ctrl.md
Name: uart_rx_pkt_ctrl

Overview:
Packet-level controller sitting directly behind the UART receiver. It consumes the receiver's per-byte rx_valid/rx_saved output and hunts for a sync byte. It then sequences the length, payload and checksum phases, buffers the payload, and releases verified packets to downstream logic on a valid/ready byte stream. Malformed, timed-out or overrun frames are dropped and reported on one-cycle error pulses.

Parameters:
CLK_FRQ, 250000000, clock frequency in Hz
BAUD_RATE, 115200, line rate in bits/s; BAUD_DIV = CLK_FRQ / BAUD_RATE
BYTE, 8, byte width
MAX_LEN, 16, maximum payload bytes (1..255)
SYNC, 8'hA5, start-of-packet byte
TIMEOUT_BITS, 20, inter-byte timeout in bit times; limit = TIMEOUT_BITS * BAUD_DIV clk cycles

Ports:
clk  input  1  clock
areset  input  1  asynchronous, active-high reset
rx_valid  input  1  one-cycle pulse; rx_byte holds a new received byte
rx_byte  input  BYTE  byte from receiver
pkt_data  output  BYTE  payload byte being offered
pkt_valid  output  1  pkt_data valid
pkt_ready  input  1  downstream accepts byte when pkt_valid && pkt_ready
pkt_last  output  1  high with the final payload byte of a packet
pkt_len  output  8  length of packet being drained; stable while draining
busy  output  1  high in any state other than HUNT
err_len  output  1  pulse: length byte 0 or > MAX_LEN
err_chk  output  1  pulse: checksum mismatch
err_timeout  output  1  pulse: inter-byte timeout expired mid-frame
err_overflow  output  1  pulse: byte arrived while draining; byte discarded

Behaviour:
- Clock and reset: clk is the clock. areset is asynchronous and active-high.
- Reset: state HUNT. pkt_valid, pkt_last, busy and all err_* are 0. pkt_data, pkt_len, byte index, XOR accumulator and timeout counter are 0. Buffer contents are don't-care. Reset mid-packet or mid-drain discards everything, with no error pulse.
- Frame format: SYNC, LEN, LEN payload bytes, CHK. CHK = LEN XOR payload[0] XOR ... XOR payload[LEN-1].
- State machine (registered; all transitions on a rx_valid cycle unless noted):
  - HUNT: rx_byte == SYNC -> LEN; other bytes are ignored silently.
  - LEN: 1 <= rx_byte <= MAX_LEN -> store length, acc = rx_byte, index = 0, go to PAYLOAD. Otherwise pulse err_len and go to HUNT. A SYNC value in LEN is treated as a length, not a resync.
  - PAYLOAD: buf[index] = rx_byte, acc ^= rx_byte, index += 1. When index == len-1 is written -> CHECK.
  - CHECK: rx_byte == acc -> DRAIN, index = 0, pkt_len = len. Otherwise pulse err_chk and go to HUNT.
  - DRAIN: pkt_valid = 1, pkt_data = buf[index], pkt_last = (index == pkt_len-1). On handshake, index += 1. On handshake with pkt_last -> HUNT, with pkt_valid low the next cycle.
- Latency: the CHK byte's rx_valid at cycle N gives pkt_valid = 1 at cycle N+1. pkt_data and pkt_last are registered and held stable while pkt_valid && !pkt_ready. Back-to-back handshakes give one byte per cycle.
- Timeout:
  - The counter runs only in LEN, PAYLOAD and CHECK, clears on every rx_valid, and clears on entry to those states.
  - Reaching limit-1 without rx_valid -> pulse err_timeout and go to HUNT.
  - rx_valid on the expiry cycle: the byte wins; it is processed and there is no timeout.
  - No timeout in HUNT or DRAIN; DRAIN waits on pkt_ready indefinitely.
- Overflow: rx_valid in DRAIN pulses err_overflow and the byte is dropped. Dropped bytes are not parsed for SYNC, so the next frame is found only after the drain completes.
- Error pulses are exactly one cycle wide and mutually exclusive in any cycle.
- Widths: index and length use 8 bits. The XOR accumulator is BYTE wide. The timeout counter is wide enough for TIMEOUT_BITS*BAUD_DIV.

Test Plan:
1. Bytes A5,03,11,22,44,CHK=0x74, pkt_ready tied 1 -> pkt_data 11,22,44 on three consecutive cycles starting 1 cycle after CHK; pkt_last on 44; pkt_len=3; no error pulses.
2. Same frame with CHK=0x75 -> err_chk one pulse, pkt_valid never asserts, busy drops next cycle. A following valid frame is delivered correctly.
3. A5,00 then A5,11 (MAX_LEN=16) -> err_len pulses twice, state back to HUNT each time; junk bytes 00,FF before A5 raise no error.
4. A5,02,10, then silence for TIMEOUT_BITS*BAUD_DIV cycles -> err_timeout pulse, busy=0. Repeat with a byte arriving exactly on the expiry cycle -> no timeout, frame continues.
5. Valid frame with pkt_ready held 0 for 50 cycles while a byte 0x5A arrives -> err_overflow pulse; pkt_data and pkt_last stable; 0x5A never emitted. Raise pkt_ready -> full packet drained.
6. areset asserted mid-PAYLOAD and mid-DRAIN -> all outputs 0 immediately. After release, a fresh frame A5,01,7E,7F is delivered as a single byte 7E with pkt_last=1.
